// File: rtl/flog_pkg.sv
`default_nettype none
// ============================================================================
// flog_pkg : bfloat16 logarithm shared types, widths and special constants
// Revision : 1.0
// ============================================================================
package flog_pkg;

   localparam int S_WIDTH   = 1;
   localparam int EXP_WIDTH = 8;
   localparam int MAN_WIDTH = 7;
   localparam int DATA_W    = S_WIDTH + EXP_WIDTH + MAN_WIDTH;

   localparam logic [DATA_W-1:0] PLUS_INF  = 16'h7F80;
   localparam logic [DATA_W-1:0] MINUS_INF = 16'hFF80;
   localparam logic [DATA_W-1:0] PLUS_ZERO = 16'h0000;
   localparam logic [DATA_W-1:0] QNAN      = 16'h7FC0;
   localparam logic [DATA_W-1:0] ONE       = 16'h3F80;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } flog_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/flog_special_detect.sv
`default_nettype none
// ============================================================================
// flog_special_detect : classifies a bfloat16 operand and gives log() of IEEE specials
// Revision : 1.0
// ============================================================================
module flog_special_detect
   import flog_pkg::*;
(
   input  logic [DATA_W-1:0] op_i,
   output logic              is_special_o,
   output logic [DATA_W-1:0] result_o
);

   logic                 sign;
   logic [EXP_WIDTH-1:0] expo;
   logic [MAN_WIDTH-1:0] man;

   assign {sign, expo, man} = op_i;

   // Priority order matters: NaN beats sign, sign beats zero/denormal.
   always_comb begin
      is_special_o = 1'b1;
      result_o     = QNAN;
      if (expo == '1 && man != '0) begin
         result_o = QNAN;
      end else if (sign && op_i[DATA_W-2:0] != '0) begin
         result_o = QNAN;
      end else if (expo == '0) begin
         result_o = MINUS_INF;
      end else if (op_i == PLUS_INF) begin
         result_o = PLUS_INF;
      end else if (op_i == ONE) begin
         result_o = PLUS_ZERO;
      end else begin
         is_special_o = 1'b0;
         result_o     = PLUS_ZERO;
      end
   end

endmodule
`default_nettype wire

// File: rtl/flog_scheduler.sv
`default_nettype none
// ============================================================================
// flog_scheduler : round-robin sequencer sharing one multi-cycle bfloat16 log core
// Revision : 1.0
// ============================================================================
module flog_scheduler
   import flog_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64
)(
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_op_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic [NUM_REQ-1:0]             resp_valid_o,
   input  logic [NUM_REQ-1:0]             resp_ready_i,
   output logic [DATA_W-1:0]              resp_result_o,
   output logic                           resp_err_o,
   output logic                           core_start_o,
   output logic [DATA_W-1:0]              core_op_o,
   input  logic                           core_done_i,
   input  logic [DATA_W-1:0]              core_result_i
);

   localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int                WD_W      = $clog2(TIMEOUT) + 1;
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
   localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);
   localparam logic [PTR_W:0]    NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

   flog_sched_state_t  state_q,  state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   grant_q,  grant_d;
   logic [DATA_W-1:0]  op_q,     op_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic               err_q,    err_d;
   logic [WD_W-1:0]    wdog_q,   wdog_d;

   logic               any_valid;
   logic [PTR_W-1:0]   pick;
   logic [PTR_W:0]     idx_sum;
   logic               spec_hit;
   logic [DATA_W-1:0]  spec_res;

   // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
   always_comb begin
      any_valid = 1'b0;
      pick      = rr_ptr_q;
      idx_sum   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
         if (idx_sum >= NUM_REQ_W) begin
            idx_sum = idx_sum - NUM_REQ_W;
         end
         if (req_valid_i[idx_sum[PTR_W-1:0]]) begin
            any_valid = 1'b1;
            pick      = idx_sum[PTR_W-1:0];
         end
      end
   end

   flog_special_detect u_special (
      .op_i         (req_op_i[pick]),
      .is_special_o (spec_hit),
      .result_o     (spec_res)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      op_d        = op_q;
      result_d    = result_q;
      err_d       = err_q;
      wdog_d      = wdog_q;
      req_ready_o = '0;
      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               req_ready_o[pick] = 1'b1;
               grant_d           = pick;
               op_d              = req_op_i[pick];
               if (spec_hit) begin
                  result_d = spec_res;
                  err_d    = 1'b0;
                  state_d  = RESP;
               end else begin
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: begin
            wdog_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wdog_d = wdog_q + 1'b1;
            // A done arriving on the timeout cycle takes precedence.
            if (core_done_i) begin
               result_d = core_result_i;
               err_d    = 1'b0;
               state_d  = RESP;
            end else if (wdog_d == WD_LAST) begin
               result_d = QNAN;
               err_d    = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (resp_ready_i[grant_q]) begin
               rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         op_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         wdog_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         op_q     <= op_d;
         result_q <= result_d;
         err_q    <= err_d;
         wdog_q   <= wdog_d;
      end
   end

   always_comb begin
      resp_valid_o = '0;
      if (state_q == RESP) begin
         resp_valid_o[grant_q] = 1'b1;
      end
   end

   assign core_start_o  = (state_q == ISSUE);
   assign core_op_o     = op_q;
   assign resp_result_o = result_q;
   assign resp_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_flog_scheduler.sv
`default_nettype none
// ============================================================================
// tb_flog_scheduler : directed self-checking bench for flog_scheduler
// Revision : 1.0
// ============================================================================
module tb_flog_scheduler;
   import flog_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 64;

   logic                           clk;
   logic                           rst_n;
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_op;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0]             resp_valid;
   logic [NUM_REQ-1:0]             resp_ready;
   logic [DATA_W-1:0]              resp_result;
   logic                           resp_err;
   logic                           core_start;
   logic [DATA_W-1:0]              core_op;
   logic                           core_done;
   logic [DATA_W-1:0]              core_result;

   int n_cmp   = 0;
   int n_err   = 0;
   int n_start = 0;

   flog_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_valid_i   (req_valid),
      .req_op_i      (req_op),
      .req_ready_o   (req_ready),
      .resp_valid_o  (resp_valid),
      .resp_ready_i  (resp_ready),
      .resp_result_o (resp_result),
      .resp_err_o    (resp_err),
      .core_start_o  (core_start),
      .core_op_o     (core_op),
      .core_done_i   (core_done),
      .core_result_i (core_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (core_start === 1'b1) n_start++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      rst_n       = 1'b0;
      req_valid   = '0;
      req_op      = '0;
      resp_ready  = '0;
      core_done   = 1'b0;
      core_result = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " req_ready"},  32'(req_ready),  32'h0);
      check({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
      check({tag, " core_start"}, 32'(core_start), 32'h0);
      check({tag, " core_op"},    32'(core_op),    32'h0);
      check({tag, " result"},     32'(resp_result), 32'h0);
      check({tag, " err"},        32'(resp_err),   32'h0);
   endtask

   task automatic do_special(input int r, input logic [15:0] op, input logic [15:0] exp, input string tag);
      int s0 = n_start;
      req_valid    = '0;
      req_valid[r] = 1'b1;
      req_op[r]    = op;
      #1 check({tag, " ready"}, 32'(req_ready), 32'(1 << r));
      tick();
      req_valid = '0;
      #1;
      check({tag, " valid"},  32'(resp_valid),  32'(1 << r));
      check({tag, " result"}, 32'(resp_result), 32'(exp));
      check({tag, " err"},    32'(resp_err),    32'h0);
      resp_ready[r] = 1'b1;
      tick();
      resp_ready = '0;
      #1;
      check({tag, " valid drop"}, 32'(resp_valid), 32'h0);
      check({tag, " no start"},   32'(n_start),    32'(s0));
   endtask

   task automatic do_normal(input int r, input logic [15:0] op, input int k, input logic [15:0] res, input string tag);
      req_valid    = '0;
      req_valid[r] = 1'b1;
      req_op[r]    = op;
      #1 check({tag, " ready"}, 32'(req_ready), 32'(1 << r));
      tick();
      req_valid = '0;
      #1;
      check({tag, " start"},   32'(core_start), 32'h1);
      check({tag, " core_op"}, 32'(core_op),    32'(op));
      for (int i = 0; i < k; i++) tick();
      core_done   = 1'b1;
      core_result = res;
      #1;
      check({tag, " no early valid"}, 32'(resp_valid), 32'h0);
      check({tag, " op stable"},      32'(core_op),    32'(op));
      tick();
      core_done   = 1'b0;
      core_result = '0;
      #1;
      check({tag, " valid"},  32'(resp_valid),  32'(1 << r));
      check({tag, " result"}, 32'(resp_result), 32'(res));
      check({tag, " err"},    32'(resp_err),    32'h0);
      resp_ready[r] = 1'b1;
      tick();
      resp_ready = '0;
   endtask

   initial begin
      apply_reset();
      #1 check_idle_outputs("reset");

      do_special(1, 16'h0000, 16'hFF80, "pzero");
      do_normal(0, 16'h4000, 5, 16'h3F31, "two");

      do_special(2, 16'hBF80, 16'h7FC0, "neg_one");
      do_special(3, 16'h7FC1, 16'h7FC0, "nan");
      do_special(0, 16'h7F80, 16'h7F80, "pinf");
      do_special(1, 16'h3F80, 16'h0000, "one");
      do_special(2, 16'hFF80, 16'h7FC0, "ninf");
      do_special(3, 16'h8000, 16'hFF80, "nzero");
      do_special(0, 16'h0001, 16'hFF80, "denorm");

      // Round-robin fairness from a fresh reset.
      apply_reset();
      req_valid  = '1;
      for (int i = 0; i < NUM_REQ; i++) req_op[i] = 16'h3F80;
      resp_ready = '1;
      for (int n = 0; n < 5; n++) begin
         #1 check($sformatf("rr grant %0d", n), 32'(req_ready), 32'(1 << (n % NUM_REQ)));
         tick();
         #1 check($sformatf("rr resp %0d", n), 32'(resp_valid), 32'(1 << (n % NUM_REQ)));
         tick();
      end
      req_valid  = '0;
      resp_ready = '0;

      // Watchdog: core never answers.
      tick();
      begin
         int s0;
         req_valid[2] = 1'b1;
         req_op[2]    = 16'h4000;
         #1 check("to ready", 32'(req_ready), 32'h4);
         tick();
         req_valid = '0;
         #1 check("to start", 32'(core_start), 32'h1);
         for (int t = 2; t <= TIMEOUT; t++) tick();
         #1 check("to no early valid", 32'(resp_valid), 32'h0);
         tick();
         #1;
         check("to valid",  32'(resp_valid),  32'h4);
         check("to result", 32'(resp_result), 32'h7FC0);
         check("to err",    32'(resp_err),    32'h1);
         resp_ready[2] = 1'b1;
         tick();
         resp_ready  = '0;
         s0          = n_start;
         core_done   = 1'b1;
         core_result = 16'h1234;
         tick();
         core_done   = 1'b0;
         #1;
         check("late done valid", 32'(resp_valid), 32'h0);
         tick();
         #1;
         check("late done valid2", 32'(resp_valid), 32'h0);
         check("late done start",  32'(n_start),    32'(s0));
      end
      do_normal(3, 16'h4000, 1, 16'h4100, "after_to");

      // Asynchronous reset while waiting on the core.
      do_special(1, 16'h3F80, 16'h0000, "pre_rst");
      req_valid[2] = 1'b1;
      req_op[2]    = 16'h4000;
      tick();
      req_valid = '0;
      tick();
      tick();
      #1 rst_n = 1'b0;
      #1 check_idle_outputs("async rst");
      tick();
      tick();
      rst_n = 1'b1;
      core_done   = 1'b1;
      core_result = 16'h5555;
      tick();
      core_done = 1'b0;
      tick();
      #1;
      check("post rst valid", 32'(resp_valid),  32'h0);
      check("post rst start", 32'(core_start),  32'h0);
      check("post rst result", 32'(resp_result), 32'h0);
      req_valid = '1;
      #1 check("post rst rr_ptr", 32'(req_ready), 32'h1);
      req_valid = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
